// File: rtl/phasor_step_scheduler.sv
// ---------------------------------------------------------------------------
// phasor_step_scheduler
//   Sequences the phasor oscillator bank so the HPS no longer bit-bangs the
//   step clock and reset. Shadow config is written per channel and copied to
//   the active config atomically. The scheduler resets the phasors, issues
//   one-cycle step enables every div+1 cycles, waits SETTLE_CYC cycles after
//   each step, then captures every phasor output into a snapshot that is
//   handed to the HPS with a valid/ack handshake.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | stepping off, ph_reset high, commit applies immediately
//   RESET | ph_reset high for RST_CYC cycles before stepping starts
//   RUN   | counting toward the next step
//   SETTLE| step issued, waiting SETTLE_CYC cycles before capture
//
// Ports
//   clk, reset_n            system clock, async active-low reset
//   run, div                stepping enable, step period minus 1
//   cfg_wr, cfg_ch,
//   cfg_sin/cos/freq        shadow config write
//   commit                  copy shadow to active (deferred while stepping)
//   ph_sin_mag/cos_mag/freq active config, ch0 in the LSBs
//   ph_step, ph_reset       phasor step enable and reset
//   ph_out                  phasor outputs, ch0 in the LSBs
//   smp_data, smp_valid,
//   smp_ack                 snapshot and its handshake
//   overrun                 sticky: a capture was dropped
//   state                   FSM state (0 IDLE, 1 RESET, 2 RUN, 3 SETTLE)
// ---------------------------------------------------------------------------
module phasor_step_scheduler #(
  parameter int NUM_CH     = 2,
  parameter int CFG_W      = 4,
  parameter int OUT_W      = 20,
  parameter int DIV_W      = 16,
  parameter int RST_CYC    = 4,
  parameter int SETTLE_CYC = 2,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    run,
  input  logic [DIV_W-1:0]        div,
  input  logic                    cfg_wr,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [CFG_W-1:0]        cfg_sin,
  input  logic [CFG_W-1:0]        cfg_cos,
  input  logic [CFG_W-1:0]        cfg_freq,
  input  logic                    commit,
  output logic [NUM_CH*CFG_W-1:0] ph_sin_mag,
  output logic [NUM_CH*CFG_W-1:0] ph_cos_mag,
  output logic [NUM_CH*CFG_W-1:0] ph_freq,
  output logic                    ph_step,
  output logic                    ph_reset,
  input  logic [NUM_CH*OUT_W-1:0] ph_out,
  output logic [NUM_CH*OUT_W-1:0] smp_data,
  output logic                    smp_valid,
  input  logic                    smp_ack,
  output logic                    overrun,
  output logic [1:0]              state
);

  localparam int SC_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int SC_W   = $clog2(SC_MAX + 1);
  localparam logic [SC_W-1:0] SC_RST    = SC_W'(RST_CYC - 1);
  localparam logic [SC_W-1:0] SC_SETTLE = SC_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RESET  = 2'd1,
    S_RUN    = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  state_t                  r_state;
  logic [DIV_W-1:0]        r_cnt;
  logic [SC_W-1:0]         r_sc;
  logic                    r_defer;
  logic                    r_pending;
  logic                    r_ph_step;
  logic                    r_ph_reset;
  logic [NUM_CH*CFG_W-1:0] r_sh_sin, r_sh_cos, r_sh_freq;
  logic [NUM_CH*CFG_W-1:0] r_act_sin, r_act_cos, r_act_freq;
  logic [NUM_CH*OUT_W-1:0] r_smp_data;
  logic                    r_smp_valid;
  logic                    r_overrun;

  // Shadow including this cycle's write, so a same-cycle commit picks it up.
  // Out-of-range channel indices match no slot and are dropped.
  logic [NUM_CH*CFG_W-1:0] w_sh_sin, w_sh_cos, w_sh_freq;

  always_comb begin
    w_sh_sin  = r_sh_sin;
    w_sh_cos  = r_sh_cos;
    w_sh_freq = r_sh_freq;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_wr && (cfg_ch == CH_W'(i))) begin
        w_sh_sin[i*CFG_W +: CFG_W]  = cfg_sin;
        w_sh_cos[i*CFG_W +: CFG_W]  = cfg_cos;
        w_sh_freq[i*CFG_W +: CFG_W] = cfg_freq;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sc        <= '0;
      r_defer     <= 1'b0;
      r_pending   <= 1'b0;
      r_ph_step   <= 1'b0;
      r_ph_reset  <= 1'b1;
      r_sh_sin    <= '0;
      r_sh_cos    <= '0;
      r_sh_freq   <= '0;
      r_act_sin   <= '0;
      r_act_cos   <= '0;
      r_act_freq  <= '0;
      r_smp_data  <= '0;
      r_smp_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_ph_step <= 1'b0;
      r_sh_sin  <= w_sh_sin;
      r_sh_cos  <= w_sh_cos;
      r_sh_freq <= w_sh_freq;
      // A capture later in this block overrides this clear.
      if (smp_ack && r_smp_valid) r_smp_valid <= 1'b0;

      if (r_state == S_IDLE) begin
        if (run) begin
          r_act_sin  <= w_sh_sin;
          r_act_cos  <= w_sh_cos;
          r_act_freq <= w_sh_freq;
          r_overrun  <= 1'b0;
          r_sc       <= SC_RST;
          r_state    <= S_RESET;
        end else if (commit) begin
          r_act_sin  <= w_sh_sin;
          r_act_cos  <= w_sh_cos;
          r_act_freq <= w_sh_freq;
        end
      end else if (!run) begin
        // Abort: no step, no capture; a pending commit lands on the way out.
        r_state    <= S_IDLE;
        r_ph_reset <= 1'b1;
        r_defer    <= 1'b0;
        r_pending  <= 1'b0;
        if (r_pending || commit) begin
          r_act_sin  <= w_sh_sin;
          r_act_cos  <= w_sh_cos;
          r_act_freq <= w_sh_freq;
        end
      end else begin
        if (commit) r_pending <= 1'b1;
        case (r_state)
          S_RESET: begin
            if (r_sc == '0) begin
              r_state    <= S_RUN;
              r_cnt      <= '0;
              r_ph_reset <= 1'b0;
              r_defer    <= 1'b0;
            end else begin
              r_sc <= r_sc - SC_W'(1);
            end
          end
          S_RUN: begin
            if (r_defer || (r_cnt == div)) begin
              r_ph_step <= 1'b1;
              r_cnt     <= '0;
              r_defer   <= 1'b0;
              r_sc      <= SC_SETTLE;
              r_state   <= S_SETTLE;
            end else begin
              r_cnt <= r_cnt + DIV_W'(1);
            end
          end
          S_SETTLE: begin
            r_cnt <= r_cnt + DIV_W'(1);
            // A period shorter than the settle window stretches to it.
            if (r_cnt == div) r_defer <= 1'b1;
            if (r_sc == '0) begin
              if (r_smp_valid && !smp_ack) begin
                r_overrun <= 1'b1;
              end else begin
                r_smp_data  <= ph_out;
                r_smp_valid <= 1'b1;
              end
              if (r_pending || commit) begin
                r_act_sin  <= w_sh_sin;
                r_act_cos  <= w_sh_cos;
                r_act_freq <= w_sh_freq;
                r_pending  <= 1'b0;
                r_defer    <= 1'b0;
                r_sc       <= SC_RST;
                r_state    <= S_RESET;
                r_ph_reset <= 1'b1;
              end else begin
                r_state <= S_RUN;
              end
            end else begin
              r_sc <= r_sc - SC_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ph_sin_mag = r_act_sin;
  assign ph_cos_mag = r_act_cos;
  assign ph_freq    = r_act_freq;
  assign ph_step    = r_ph_step;
  assign ph_reset   = r_ph_reset;
  assign smp_data   = r_smp_data;
  assign smp_valid  = r_smp_valid;
  assign overrun    = r_overrun;
  assign state      = r_state;

endmodule

// File: tb/tb_phasor_step_scheduler.sv
// ---------------------------------------------------------------------------
// tb_phasor_step_scheduler
//   Scoreboard bench. The stimulus process drives one cycle at a time and
//   advances a schedule-based reference model (absolute cycle numbers for
//   reset end, next step and next capture); the expected outputs for that
//   cycle go into a queue. A monitor pops one entry per cycle at the falling
//   edge and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_phasor_step_scheduler;
  localparam int NUM_CH     = 2;
  localparam int CFG_W      = 4;
  localparam int OUT_W      = 20;
  localparam int DIV_W      = 16;
  localparam int RST_CYC    = 4;
  localparam int SETTLE_CYC = 2;
  localparam int AW         = NUM_CH * CFG_W;
  localparam int DW         = NUM_CH * OUT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             run;
  logic [DIV_W-1:0] div;
  logic             cfg_wr;
  logic [0:0]       cfg_ch;
  logic [CFG_W-1:0] cfg_sin, cfg_cos, cfg_freq;
  logic             commit;
  logic [AW-1:0]    ph_sin_mag, ph_cos_mag, ph_freq;
  logic             ph_step, ph_reset;
  logic [DW-1:0]    ph_out;
  logic [DW-1:0]    smp_data;
  logic             smp_valid, smp_ack, overrun;
  logic [1:0]       state;

  phasor_step_scheduler #(
    .NUM_CH(NUM_CH), .CFG_W(CFG_W), .OUT_W(OUT_W), .DIV_W(DIV_W),
    .RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .div(div),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_sin(cfg_sin), .cfg_cos(cfg_cos),
    .cfg_freq(cfg_freq), .commit(commit),
    .ph_sin_mag(ph_sin_mag), .ph_cos_mag(ph_cos_mag), .ph_freq(ph_freq),
    .ph_step(ph_step), .ph_reset(ph_reset), .ph_out(ph_out),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ack(smp_ack),
    .overrun(overrun), .state(state)
  );

  typedef struct {
    int            cyc;
    logic [1:0]    st;
    logic          step;
    logic          rst;
    logic [AW-1:0] sin, cos, freq;
    logic [DW-1:0] data;
    logic          valid;
    logic          ovr;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Drive values for the upcoming cycle and the values of the previous one.
  bit             d_rst_n, d_run, d_cfg_wr, d_commit, d_ack;
  int             d_div, d_ch;
  logic [CFG_W-1:0] d_sin, d_cos, d_freq;
  logic [DW-1:0]  d_ph_out;
  bit             p_rst_n, p_run, p_cfg_wr, p_commit, p_ack;
  int             p_div, p_ch;
  logic [CFG_W-1:0] p_sin, p_cos, p_freq;
  logic [DW-1:0]  p_ph_out;
  bit             ack_rand;

  // Reference model.
  int               cyc;
  bit               m_busy, m_pend, m_step, m_valid, m_ovr;
  int               m_run_begin, m_next_step, m_cap;
  logic [DW-1:0]    m_data;
  logic [CFG_W-1:0] m_sh_sin[NUM_CH], m_sh_cos[NUM_CH], m_sh_freq[NUM_CH];
  logic [CFG_W-1:0] m_ac_sin[NUM_CH], m_ac_cos[NUM_CH], m_ac_freq[NUM_CH];

  task automatic model_reset();
    m_busy = 0; m_pend = 0; m_step = 0; m_valid = 0; m_ovr = 0;
    m_run_begin = 0; m_next_step = 0; m_cap = 0; m_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_sh_sin[i] = '0; m_sh_cos[i] = '0; m_sh_freq[i] = '0;
      m_ac_sin[i] = '0; m_ac_cos[i] = '0; m_ac_freq[i] = '0;
    end
  endtask

  // Effect of the clock edge that ends cycle cyc-1, using that cycle's inputs.
  task automatic model_edge();
    logic [CFG_W-1:0] ns_sin[NUM_CH], ns_cos[NUM_CH], ns_freq[NUM_CH];
    bit v0;
    bit apply;
    int per;
    ns_sin = m_sh_sin; ns_cos = m_sh_cos; ns_freq = m_sh_freq;
    if (p_cfg_wr && p_ch < NUM_CH) begin
      ns_sin[p_ch] = p_sin; ns_cos[p_ch] = p_cos; ns_freq[p_ch] = p_freq;
    end
    apply  = 0;
    m_step = 0;
    v0 = m_valid;
    if (m_valid && p_ack) m_valid = 0;
    if (!m_busy) begin
      if (p_run) begin
        m_busy = 1; apply = 1; m_ovr = 0; m_cap = 0;
        m_run_begin = cyc + RST_CYC;
        m_next_step = m_run_begin + p_div + 1;
      end else if (p_commit) begin
        apply = 1;
      end
    end else if (!p_run) begin
      m_busy = 0;
      if (m_pend || p_commit) apply = 1;
      m_pend = 0; m_cap = 0; m_next_step = 0; m_run_begin = 0;
    end else begin
      if (p_commit) m_pend = 1;
      if (m_cap == cyc) begin
        if (v0 && !p_ack) m_ovr = 1;
        else begin
          m_data = p_ph_out; m_valid = 1;
        end
        if (m_pend) begin
          apply = 1; m_pend = 0;
          m_run_begin = cyc + RST_CYC;
          m_next_step = m_run_begin + p_div + 1;
        end
      end else if (m_next_step == cyc) begin
        m_step = 1;
        m_cap  = cyc + SETTLE_CYC;
        per = (p_div + 1 > SETTLE_CYC + 1) ? p_div + 1 : SETTLE_CYC + 1;
        m_next_step = cyc + per;
      end
    end
    if (apply) begin
      m_ac_sin = ns_sin; m_ac_cos = ns_cos; m_ac_freq = ns_freq;
    end
    m_sh_sin = ns_sin; m_sh_cos = ns_cos; m_sh_freq = ns_freq;
  endtask

  function automatic logic [1:0] model_state();
    if (!m_busy)                return 2'd0;
    else if (cyc < m_run_begin) return 2'd1;
    else if (cyc < m_cap)       return 2'd3;
    else                        return 2'd2;
  endfunction

  task automatic apply_inputs();
    reset_n  = d_rst_n;
    run      = d_run;
    div      = DIV_W'(d_div);
    cfg_wr   = d_cfg_wr;
    cfg_ch   = 1'(d_ch);
    cfg_sin  = d_sin;
    cfg_cos  = d_cos;
    cfg_freq = d_freq;
    commit   = d_commit;
    smp_ack  = d_ack;
    ph_out   = d_ph_out;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (p_rst_n) model_edge();
    else m_step = 0;
    d_ph_out = DW'({$urandom, $urandom});
    if (ack_rand) d_ack = ($urandom_range(0, 3) == 0);
    apply_inputs();
    if (!d_rst_n) model_reset();
    e.cyc   = cyc;
    e.st    = model_state();
    e.step  = m_step;
    e.rst   = (e.st == 2'd0) || (e.st == 2'd1);
    for (int i = 0; i < NUM_CH; i++) begin
      e.sin[i*CFG_W +: CFG_W]  = m_ac_sin[i];
      e.cos[i*CFG_W +: CFG_W]  = m_ac_cos[i];
      e.freq[i*CFG_W +: CFG_W] = m_ac_freq[i];
    end
    e.data  = m_data;
    e.valid = m_valid;
    e.ovr   = m_ovr;
    sb_q.push_back(e);
    p_rst_n = d_rst_n; p_run = d_run; p_cfg_wr = d_cfg_wr; p_commit = d_commit;
    p_ack = d_ack; p_div = d_div; p_ch = d_ch; p_sin = d_sin; p_cos = d_cos;
    p_freq = d_freq; p_ph_out = d_ph_out;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic cfg_write(input int ch, input int s, input int c, input int f,
                           input bit with_commit);
    d_cfg_wr = 1; d_ch = ch;
    d_sin = CFG_W'(s); d_cos = CFG_W'(c); d_freq = CFG_W'(f);
    d_commit = with_commit;
    tick();
    d_cfg_wr = 0; d_commit = 0;
  endtask

  task automatic pulse_commit();
    d_commit = 1; tick(); d_commit = 0;
  endtask

  task automatic pulse_ack();
    d_ack = 1; tick(); d_ack = 0;
  endtask

  // Bounded: advances until the model issues a step or the budget runs out.
  task automatic until_step(input int budget);
    for (int k = 0; k < budget; k++) begin
      tick();
      if (m_step) break;
    end
  endtask

  task automatic chk(input string name, input int c, input logic [63:0] got,
                     input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, want %h", name, c, got, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("state",     e.cyc, 64'(state),      64'(e.st));
      chk("ph_step",   e.cyc, 64'(ph_step),    64'(e.step));
      chk("ph_reset",  e.cyc, 64'(ph_reset),   64'(e.rst));
      chk("ph_sin",    e.cyc, 64'(ph_sin_mag), 64'(e.sin));
      chk("ph_cos",    e.cyc, 64'(ph_cos_mag), 64'(e.cos));
      chk("ph_freq",   e.cyc, 64'(ph_freq),    64'(e.freq));
      chk("smp_data",  e.cyc, 64'(smp_data),   64'(e.data));
      chk("smp_valid", e.cyc, 64'(smp_valid),  64'(e.valid));
      chk("overrun",   e.cyc, 64'(overrun),    64'(e.ovr));
    end
  end

  initial begin
    cyc = 0;
    d_rst_n = 0; d_run = 0; d_cfg_wr = 0; d_commit = 0; d_ack = 0;
    d_div = 0; d_ch = 0; d_sin = '0; d_cos = '0; d_freq = '0; d_ph_out = '0;
    ack_rand = 0;
    p_rst_n = 0; p_run = 0; p_cfg_wr = 0; p_commit = 0; p_ack = 0;
    p_div = 0; p_ch = 0; p_sin = '0; p_cos = '0; p_freq = '0; p_ph_out = '0;
    model_reset();
    apply_inputs();

    ticks(3);
    d_rst_n = 1;
    ticks(2);

    // Config write then commit in IDLE; then a write+commit in one cycle.
    cfg_write(0, 3, 5, 2, 0);
    pulse_commit();
    ticks(2);
    cfg_write(1, 9, 10, 11, 1);
    ticks(2);

    // Start with div=9; hold ack low across captures to force an overrun.
    d_div = 9;
    tick();
    d_run = 1;
    ticks(20);
    pulse_ack();
    ticks(12);
    ticks(12);
    pulse_ack();
    ticks(4);

    // Commit mid-run with a new ch1 frequency.
    cfg_write(1, 9, 10, 7, 0);
    ticks(3);
    pulse_commit();
    ticks(3);
    pulse_commit();
    ack_rand = 1;
    ticks(30);

    // Minimum period: div=0 is stretched by the settle window.
    d_run = 0;
    ticks(2);
    d_div = 0;
    tick();
    d_run = 1;
    ticks(40);

    // Async reset in the middle of SETTLE, release with run low.
    until_step(40);
    d_rst_n = 0;
    tick();
    d_run = 0;
    ticks(2);
    d_rst_n = 1;
    ticks(4);
    d_div = 5;
    tick();
    d_run = 1;
    ticks(30);

    // Randomised episodes.
    for (int ep = 0; ep < 40; ep++) begin
      d_run = 0;
      ticks(2);
      d_div = $urandom_range(0, 12);
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        if ($urandom_range(0, 1) == 1)
          cfg_write($urandom_range(0, 1), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 3) == 0);
        else tick();
      end
      d_run = 1;
      for (int k = 0; k < int'($urandom_range(15, 80)); k++) begin
        d_cfg_wr = ($urandom_range(0, 7) == 0);
        d_ch     = $urandom_range(0, 1);
        d_sin    = CFG_W'($urandom_range(0, 15));
        d_cos    = CFG_W'($urandom_range(0, 15));
        d_freq   = CFG_W'($urandom_range(0, 15));
        d_commit = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 199) == 0) d_rst_n = 0;
        tick();
        d_rst_n = 1;
      end
      d_cfg_wr = 0;
      d_commit = 0;
    end
    d_run = 0;
    ticks(4);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
